// File: rtl/spi_master_calc_pkg.sv
// Shared types and constants for the SPI mode-0 master that talks to the adder slave.
// Frame layout is x, y, then a dummy byte during which the slave returns the sum.
package spi_master_calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int FRAME_BITS = 24;
  localparam int BIT_CNT_W  = 5;

  localparam logic [7:0]           DUMMY_BYTE   = 8'h00;
  localparam logic [BIT_CNT_W-1:0] RX_FIRST_BIT = BIT_CNT_W'(FRAME_BITS - 8);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT     = BIT_CNT_W'(FRAME_BITS - 1);

  // Chip select is held low from SETUP through HOLD inclusive.
  function automatic logic isFrameActive(input state_e s);
    return (s == ST_SETUP) || (s == ST_SHIFT) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/spi_master_calc_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV cycles while enabled and flags which edge
// just happened, so the master can sample/shift on the same clk edge that moves sclk.
module spi_master_calc_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic             sclk_q, sclk_d;
  logic             boundary;

  // Disabling clears both counter and level, so every SHIFT phase starts from a fresh half-period.
  always_comb begin
    boundary = en_i && (divCnt_q == DIV_LAST);
    divCnt_d = '0;
    sclk_d   = 1'b0;
    if (en_i) begin
      divCnt_d = boundary ? '0 : divCnt_q + 1'b1;
      sclk_d   = boundary ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divCnt_q <= '0;
      sclk_q   <= 1'b0;
    end else begin
      divCnt_q <= divCnt_d;
      sclk_q   <= sclk_d;
    end
  end

  assign sclk_o      = sclk_q;
  assign rise_tick_o = boundary && !sclk_q;
  assign fall_tick_o = boundary && sclk_q;

endmodule

// File: rtl/spi_master_calc.sv
// SPI mode-0 master for the calc link: sends x and y, clocks a dummy byte, and
// captures the slave's sum from that third byte.
module spi_master_calc
  import spi_master_calc_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [7:0] y_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] sum_out,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int PH_W = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CS_SETUP - 1);

  if (CLK_DIV < 2) begin : gBadClkDiv
    $error("spi_master_calc: CLK_DIV must be >= 2");
  end
  if (CS_SETUP < 1) begin : gBadCsSetup
    $error("spi_master_calc: CS_SETUP must be >= 1");
  end

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   txShift_q, txShift_d;
  logic [7:0]              rxShift_q, rxShift_d;
  logic [7:0]              sumOut_q, sumOut_d;
  logic [BIT_CNT_W-1:0]    bitCnt_q, bitCnt_d;
  logic [PH_W-1:0]         phaseCnt_q, phaseCnt_d;
  logic                    csN_q, csN_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    shiftEn, sclkRise, sclkFall;

  assign shiftEn = (state_q == ST_SHIFT);

  spi_master_calc_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) uSclkGen (
    .clk        (clk),
    .rst        (rst),
    .en_i       (shiftEn),
    .sclk_o     (spi_sclk),
    .rise_tick_o(sclkRise),
    .fall_tick_o(sclkFall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      txShift_q  <= '0;
      rxShift_q  <= '0;
      sumOut_q   <= '0;
      bitCnt_q   <= '0;
      phaseCnt_q <= '0;
      csN_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      txShift_q  <= txShift_d;
      rxShift_q  <= rxShift_d;
      sumOut_q   <= sumOut_d;
      bitCnt_q   <= bitCnt_d;
      phaseCnt_q <= phaseCnt_d;
      csN_q      <= csN_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Only byte2 is kept on the receive side; the slave drives don't-care bits during x and y.
  always_comb begin
    state_d    = state_q;
    txShift_d  = txShift_q;
    rxShift_d  = rxShift_q;
    sumOut_d   = sumOut_q;
    bitCnt_d   = bitCnt_q;
    phaseCnt_d = phaseCnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          txShift_d  = {x_in, y_in, DUMMY_BYTE};
          rxShift_d  = '0;
          phaseCnt_d = '0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phaseCnt_q == PH_LAST) begin
          phaseCnt_d = '0;
          bitCnt_d   = '0;
          state_d    = ST_SHIFT;
        end else begin
          phaseCnt_d = phaseCnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sclkRise && (bitCnt_q >= RX_FIRST_BIT)) begin
          rxShift_d = {rxShift_q[6:0], spi_miso};
        end
        if (sclkFall) begin
          if (bitCnt_q == LAST_BIT) begin
            bitCnt_d = '0;
            state_d  = ST_HOLD;
          end else begin
            txShift_d = {txShift_q[FRAME_BITS-2:0], 1'b0};
            bitCnt_d  = bitCnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (phaseCnt_q == PH_LAST) begin
          phaseCnt_d = '0;
          sumOut_d   = rxShift_q;
          state_d    = ST_DONE;
        end else begin
          phaseCnt_d = phaseCnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Link outputs are registered from the next state so they never glitch on the pins.
    csN_d  = !isFrameActive(state_d);
    busy_d = isFrameActive(state_d);
    done_d = (state_d == ST_DONE);
  end

  assign spi_cs_n = csN_q;
  assign spi_mosi = txShift_q[FRAME_BITS-1];
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sumOut_q;

endmodule

// File: tb/tb_spi_master_calc.sv
// Bench for spi_master_calc: behavioural mode-0 adder slave, scoreboard of expected sums/frames,
// a vector table plus hand-written corner sequences, and a second CLK_DIV=2/CS_SETUP=1 instance.
module tb_spi_master_calc;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  // Cycle 0 is the cycle in which start is presented; done is high in cycle LATENCY.
  localparam int LATENCY  = 1 + CS_SETUP + 48 * CLK_DIV + CS_SETUP;
  localparam int CS_LOW   = 2 * CS_SETUP + 48 * CLK_DIV;
  localparam int LATENCY2 = 1 + 1 + 48 * 2 + 1;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] expSum;
  } vec_t;

  typedef struct {
    logic [7:0]  expSum;
    logic [23:0] expFrame;
  } sbEntry_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] xIn = 8'h00;
  logic [7:0] yIn = 8'h00;
  logic       busy, done, csN, sclk, mosi, miso;
  logic [7:0] sumOut;

  logic       start2 = 1'b0;
  logic [7:0] xIn2 = 8'h00;
  logic [7:0] yIn2 = 8'h00;
  logic       busy2, done2, csN2, sclk2, mosi2, miso2;
  logic [7:0] sumOut2;

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;

  sbEntry_t sbQ[$];
  vec_t     vecs[6];

  int busyRiseCyc = 0;
  int lastDoneCyc = 0;
  int prevDoneCyc = 0;
  int doneCount = 0;
  int csLowCnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_calc #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(xIn), .y_in(yIn),
    .busy(busy), .done(done), .sum_out(sumOut),
    .spi_cs_n(csN), .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso)
  );

  spi_master_calc #(.CLK_DIV(2), .CS_SETUP(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .x_in(xIn2), .y_in(yIn2),
    .busy(busy2), .done(done2), .sum_out(sumOut2),
    .spi_cs_n(csN2), .spi_sclk(sclk2), .spi_mosi(mosi2), .spi_miso(miso2)
  );

  // Mode-0 adder slave: captures MOSI on rising SCLK, drives the sum MSB-first after each fall.
  logic [23:0] s1Shift = '0, s1LastFrame = '0;
  logic [7:0]  s1Sum = '0;
  int          s1Rises = 0, s1LastRises = 0, s1Falls = 0;

  always @(posedge sclk or posedge csN) begin
    if (csN) begin
      s1LastFrame <= s1Shift;
      s1LastRises <= s1Rises;
      s1Shift     <= '0;
      s1Rises     <= 0;
    end else begin
      s1Shift <= {s1Shift[22:0], mosi};
      s1Rises <= s1Rises + 1;
      if (s1Rises == 15) s1Sum <= s1Shift[14:7] + {s1Shift[6:0], mosi};
    end
  end

  always @(negedge sclk or posedge csN) begin
    if (csN) s1Falls <= 0;
    else     s1Falls <= s1Falls + 1;
  end

  assign miso = (s1Falls >= 16 && s1Falls < 24) ? s1Sum[3'(23 - s1Falls)] : 1'b0;

  logic [23:0] s2Shift = '0, s2LastFrame = '0;
  logic [7:0]  s2Sum = '0;
  int          s2Rises = 0, s2LastRises = 0, s2Falls = 0;

  always @(posedge sclk2 or posedge csN2) begin
    if (csN2) begin
      s2LastFrame <= s2Shift;
      s2LastRises <= s2Rises;
      s2Shift     <= '0;
      s2Rises     <= 0;
    end else begin
      s2Shift <= {s2Shift[22:0], mosi2};
      s2Rises <= s2Rises + 1;
      if (s2Rises == 15) s2Sum <= s2Shift[14:7] + {s2Shift[6:0], mosi2};
    end
  end

  always @(negedge sclk2 or posedge csN2) begin
    if (csN2) s2Falls <= 0;
    else      s2Falls <= s2Falls + 1;
  end

  assign miso2 = (s2Falls >= 16 && s2Falls < 24) ? s2Sum[3'(23 - s2Falls)] : 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    xIn   = x;
    yIn   = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDones(input int n, input int budget, input string name);
    int base = doneCount;
    int k = 0;
    while (doneCount < base + n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, "_timeout"}, 32'(doneCount >= base + n), 32'd1);
  endtask

  // Scoreboard monitor for the default instance; everything is sampled on the falling clk edge.
  initial begin
    logic busyPrev = 1'b0;
    logic donePrev = 1'b0;
    sbEntry_t e;
    forever begin
      @(negedge clk);
      if (busy && !busyPrev) busyRiseCyc = cyc;
      if (donePrev) checkOutput("done_width", 32'(done), 32'd0);
      if (done) begin
        doneCount++;
        prevDoneCyc = lastDoneCyc;
        lastDoneCyc = cyc;
        checkOutput("sb_pending", 32'(sbQ.size() > 0), 32'd1);
        if (sbQ.size() > 0) begin
          e = sbQ.pop_front();
          checkOutput("sum_out", 32'(sumOut), 32'(e.expSum));
          checkOutput("mosi_frame", 32'(s1LastFrame), 32'(e.expFrame));
          checkOutput("sclk_rises", 32'(s1LastRises), 32'd24);
          checkOutput("latency", 32'(cyc - (busyRiseCyc - 1)), 32'(LATENCY));
          checkOutput("cs_low_cycles", 32'(csLowCnt), 32'(CS_LOW));
          checkOutput("busy_at_done", 32'(busy), 32'd0);
        end
        csLowCnt = 0;
      end else if (csN) begin
        csLowCnt = 0;
      end else begin
        csLowCnt++;
      end
      busyPrev = busy;
      donePrev = done;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int k;
    int t0;
    int rise1;
    int rise2;
    logic sclk2Prev;

    vecs[0] = '{8'h12, 8'h34, 8'h46};
    vecs[1] = '{8'hFF, 8'h02, 8'h01};
    vecs[2] = '{8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'h7F, 8'h01, 8'h80};
    vecs[4] = '{8'hA5, 8'h5A, 8'hFF};
    vecs[5] = '{8'h9C, 8'h64, 8'h00};

    repeat (3) @(negedge clk);
    checkOutput("reset_cs_n", 32'(csN), 32'd1);
    checkOutput("reset_sclk", 32'(sclk), 32'd0);
    checkOutput("reset_mosi", 32'(mosi), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_sum", 32'(sumOut), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      sbQ.push_back('{vecs[i].expSum, {vecs[i].x, vecs[i].y, 8'h00}});
      applyStimulus(vecs[i].x, vecs[i].y);
      waitDones(1, 400, "vector");
      repeat (2) @(negedge clk);
    end

    // A second start mid-frame must be dropped, not queued.
    base = doneCount;
    sbQ.push_back('{8'h31, 24'h211000});
    applyStimulus(8'h21, 8'h10);
    repeat (50) @(negedge clk);
    xIn = 8'hAA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDones(1, 400, "repulse");
    repeat (250) @(negedge clk);
    checkOutput("repulse_single_done", 32'(doneCount - base), 32'd1);

    // Asynchronous reset after bit 10 of a frame.
    applyStimulus(8'h55, 8'h66);
    k = 0;
    while (s1Rises < 11 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("midreset_reached_bit10", 32'(s1Rises >= 11), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_cs_n", 32'(csN), 32'd1);
    checkOutput("midreset_sclk", 32'(sclk), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_sum", 32'(sumOut), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postreset_sum", 32'(sumOut), 32'd0);
    sbQ.push_back('{8'h02, 24'h010100});
    applyStimulus(8'h01, 8'h01);
    waitDones(1, 400, "postreset");
    repeat (2) @(negedge clk);

    // Back-to-back frames with start held; each done is followed by DONE + IDLE-sample cycles.
    sbQ.push_back('{8'h30, 24'h102000});
    sbQ.push_back('{8'h70, 24'h304000});
    @(negedge clk);
    xIn = 8'h10;
    yIn = 8'h20;
    start = 1'b1;
    @(negedge clk);
    xIn = 8'h30;
    yIn = 8'h40;
    waitDones(1, 400, "b2b_first");
    k = 0;
    while (!busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    waitDones(1, 400, "b2b_second");
    checkOutput("b2b_spacing", 32'(lastDoneCyc - prevDoneCyc), 32'(LATENCY + 1));
    repeat (4) @(negedge clk);

    // CLK_DIV=2, CS_SETUP=1 instance.
    @(negedge clk);
    xIn2 = 8'h80;
    yIn2 = 8'h80;
    start2 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start2 = 1'b0;
    rise1 = -1;
    rise2 = -1;
    sclk2Prev = sclk2;
    k = 0;
    while (!done2 && k < 300) begin
      @(negedge clk);
      k++;
      if (sclk2 && !sclk2Prev) begin
        if (rise1 < 0) rise1 = cyc;
        else if (rise2 < 0) rise2 = cyc;
      end
      sclk2Prev = sclk2;
    end
    checkOutput("div2_done_seen", 32'(done2), 32'd1);
    checkOutput("div2_latency", 32'(cyc - t0), 32'(LATENCY2));
    checkOutput("div2_sum", 32'(sumOut2), 32'h00);
    checkOutput("div2_sclk_period", 32'(rise2 - rise1), 32'd4);
    checkOutput("div2_frame", 32'(s2LastFrame), 32'h808000);
    checkOutput("div2_rises", 32'(s2LastRises), 32'd24);
    repeat (3) @(negedge clk);

    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
